// File: rtl/atomrvcore_exmem.sv
// Execute/memory back-end of the atomRV core: ALU + branch unit (EX), DCCM access (MEM)
// and an independent ICCM port for fetch and the program loader.
`timescale 1ns/1ps
module atomrvcore_exmem #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5,
    parameter int ALU_OP           = 6,
    parameter int DMEM_DEPTH       = 256,
    parameter int IMEM_DEPTH       = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [ALU_OP-1:0]           ALUop_i,
    input  logic [DATAWIDTH-1:0]        PC_i,
    input  logic [DATAWIDTH-1:0]        operand_A_i,
    input  logic [DATAWIDTH-1:0]        operand_B_i,
    input  logic [DATAWIDTH-1:0]        immed_i,
    input  logic [DATAWIDTH-1:0]        R2_i,
    input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
    input  logic                        RWR_EN_i,
    input  logic                        DR_EN_i,
    input  logic                        DWR_EN_i,
    output logic [DATAWIDTH-1:0]        result_o,
    output logic                        BE_o,
    output logic [DATAWIDTH-1:0]        PC_o,
    output logic [DATAWIDTH-1:0]        WR_o,
    output logic [REG_ADRESS_WIDTH-1:0] RD_o,
    output logic                        RWR_EN_o,
    input  logic [DATAWIDTH-1:0]        IADDR_i,
    input  logic [DATAWIDTH-1:0]        IDATA_i,
    input  logic                        IWR_EN_i,
    input  logic                        IR_EN_i,
    output logic [DATAWIDTH-1:0]        instr_o
);

    localparam int DIDX_W = $clog2(DMEM_DEPTH);
    localparam int IIDX_W = $clog2(IMEM_DEPTH);

    localparam logic [ALU_OP-1:0] OP_ADD   = ALU_OP'(0);
    localparam logic [ALU_OP-1:0] OP_SUB   = ALU_OP'(1);
    localparam logic [ALU_OP-1:0] OP_SLL   = ALU_OP'(2);
    localparam logic [ALU_OP-1:0] OP_SLT   = ALU_OP'(3);
    localparam logic [ALU_OP-1:0] OP_SLTU  = ALU_OP'(4);
    localparam logic [ALU_OP-1:0] OP_XOR   = ALU_OP'(5);
    localparam logic [ALU_OP-1:0] OP_SRL   = ALU_OP'(6);
    localparam logic [ALU_OP-1:0] OP_SRA   = ALU_OP'(7);
    localparam logic [ALU_OP-1:0] OP_OR    = ALU_OP'(8);
    localparam logic [ALU_OP-1:0] OP_AND   = ALU_OP'(9);
    localparam logic [ALU_OP-1:0] OP_BEQ   = ALU_OP'(16);
    localparam logic [ALU_OP-1:0] OP_BNE   = ALU_OP'(17);
    localparam logic [ALU_OP-1:0] OP_BLT   = ALU_OP'(18);
    localparam logic [ALU_OP-1:0] OP_BGE   = ALU_OP'(19);
    localparam logic [ALU_OP-1:0] OP_BLTU  = ALU_OP'(20);
    localparam logic [ALU_OP-1:0] OP_BGEU  = ALU_OP'(21);
    localparam logic [ALU_OP-1:0] OP_JAL   = ALU_OP'(24);
    localparam logic [ALU_OP-1:0] OP_JALR  = ALU_OP'(25);
    localparam logic [ALU_OP-1:0] OP_LUI   = ALU_OP'(26);
    localparam logic [ALU_OP-1:0] OP_AUIPC = ALU_OP'(27);

    localparam logic [DATAWIDTH-1:0] NOP_INSTR = DATAWIDTH'(32'h0000_0013);

    logic signed [DATAWIDTH-1:0] a_s;
    logic signed [DATAWIDTH-1:0] b_s;
    logic [4:0]                  shamt;
    logic [DATAWIDTH-1:0]        pc_plus4;
    logic [DATAWIDTH-1:0]        br_target;
    logic [DATAWIDTH-1:0]        eff_addr;
    logic [DATAWIDTH-1:0]        jalr_target;

    logic [DATAWIDTH-1:0]        result_d;
    logic                        be_d;
    logic [DATAWIDTH-1:0]        pc_d;

    logic [DATAWIDTH-1:0]        result_q;
    logic                        be_q;
    logic [DATAWIDTH-1:0]        pc_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_ex_q;
    logic                        rwr_ex_q;
    logic                        dr_ex_q;
    logic                        dwr_ex_q;
    logic [DATAWIDTH-1:0]        sdata_ex_q;
    logic [DIDX_W-1:0]           didx_ex_q;

    logic [DATAWIDTH-1:0]        wr_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_q;
    logic                        rwr_q;

    logic [DATAWIDTH-1:0]        dmem [DMEM_DEPTH];
    logic [DATAWIDTH-1:0]        imem [IMEM_DEPTH];
    logic [IIDX_W-1:0]           iidx;
    logic                        unused_addr_bits;

    assign a_s         = operand_A_i;
    assign b_s         = operand_B_i;
    assign shamt       = operand_B_i[4:0];
    assign pc_plus4    = PC_i + DATAWIDTH'(4);
    assign br_target   = PC_i + immed_i;
    assign eff_addr    = operand_A_i + immed_i;
    assign jalr_target = eff_addr & ~DATAWIDTH'(1);

    // EX stage: ALU result and branch resolution
    always_comb begin
        result_d = '0;
        be_d     = 1'b0;
        pc_d     = pc_plus4;
        case (ALUop_i)
            OP_ADD:   result_d = operand_A_i + operand_B_i;
            OP_SUB:   result_d = operand_A_i - operand_B_i;
            OP_SLL:   result_d = operand_A_i << shamt;
            OP_SLT:   result_d = DATAWIDTH'(a_s < b_s);
            OP_SLTU:  result_d = DATAWIDTH'(operand_A_i < operand_B_i);
            OP_XOR:   result_d = operand_A_i ^ operand_B_i;
            OP_SRL:   result_d = operand_A_i >> shamt;
            OP_SRA:   result_d = $unsigned(a_s >>> shamt);
            OP_OR:    result_d = operand_A_i | operand_B_i;
            OP_AND:   result_d = operand_A_i & operand_B_i;
            OP_BEQ:   be_d = (operand_A_i == operand_B_i);
            OP_BNE:   be_d = (operand_A_i != operand_B_i);
            OP_BLT:   be_d = (a_s < b_s);
            OP_BGE:   be_d = (a_s >= b_s);
            OP_BLTU:  be_d = (operand_A_i < operand_B_i);
            OP_BGEU:  be_d = (operand_A_i >= operand_B_i);
            OP_JAL: begin
                be_d     = 1'b1;
                result_d = pc_plus4;
            end
            OP_JALR: begin
                be_d     = 1'b1;
                result_d = pc_plus4;
            end
            OP_LUI:   result_d = immed_i;
            OP_AUIPC: result_d = br_target;
            default: ;
        endcase
        if (be_d) begin
            pc_d = (ALUop_i == OP_JALR) ? jalr_target : br_target;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_q   <= '0;
            be_q       <= 1'b0;
            pc_q       <= '0;
            rd_ex_q    <= '0;
            rwr_ex_q   <= 1'b0;
            dr_ex_q    <= 1'b0;
            dwr_ex_q   <= 1'b0;
            sdata_ex_q <= '0;
            didx_ex_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            rwr_q      <= 1'b0;
        end else begin
            result_q   <= result_d;
            be_q       <= be_d;
            pc_q       <= pc_d;
            rd_ex_q    <= RD_i;
            rwr_ex_q   <= RWR_EN_i;
            dr_ex_q    <= DR_EN_i;
            dwr_ex_q   <= DWR_EN_i;
            sdata_ex_q <= R2_i;
            didx_ex_q  <= eff_addr[DIDX_W+1:2];
            // MEM stage: the read sees the word before this edge's store
            wr_q       <= dr_ex_q ? dmem[didx_ex_q] : result_q;
            rd_q       <= rd_ex_q;
            rwr_q      <= rwr_ex_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && dwr_ex_q) begin
            dmem[didx_ex_q] <= sdata_ex_q;
        end
    end

    assign iidx = IADDR_i[IIDX_W+1:2];

    always_ff @(posedge clk_i) begin
        if (rst_ni && IWR_EN_i) begin
            imem[iidx] <= IDATA_i;
        end
    end

    assign instr_o = IR_EN_i ? imem[iidx] : NOP_INSTR;

    // Byte-offset and above-depth address bits are intentionally dropped
    assign unused_addr_bits = ^{eff_addr[DATAWIDTH-1:DIDX_W+2], eff_addr[1:0],
                                IADDR_i[DATAWIDTH-1:IIDX_W+2], IADDR_i[1:0]};

    assign result_o = result_q;
    assign BE_o     = be_q;
    assign PC_o     = pc_q;
    assign WR_o     = wr_q;
    assign RD_o     = rd_q;
    assign RWR_EN_o = rwr_q;

endmodule

// File: tb/tb_atomrvcore_exmem.sv
// Bench for atomrvcore_exmem: directed scenarios plus randomized traffic against
// an instruction-level model of the EX/MEM back-end and its data memory.
`timescale 1ns/1ps
module tb_atomrvcore_exmem;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [5:0]  ALUop;
    logic [31:0] PC, opA, opB, immed, R2;
    logic [4:0]  RD;
    logic        RWR_EN, DR_EN, DWR_EN;
    logic [31:0] result_o, PC_o, WR_o;
    logic        BE_o, RWR_EN_o;
    logic [4:0]  RD_o;
    logic [31:0] IADDR, IDATA, instr_o;
    logic        IWR_EN, IR_EN;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    atomrvcore_exmem dut (
        .clk_i(clk), .rst_ni(rst_ni), .ALUop_i(ALUop), .PC_i(PC),
        .operand_A_i(opA), .operand_B_i(opB), .immed_i(immed), .R2_i(R2),
        .RD_i(RD), .RWR_EN_i(RWR_EN), .DR_EN_i(DR_EN), .DWR_EN_i(DWR_EN),
        .result_o(result_o), .BE_o(BE_o), .PC_o(PC_o), .WR_o(WR_o),
        .RD_o(RD_o), .RWR_EN_o(RWR_EN_o), .IADDR_i(IADDR), .IDATA_i(IDATA),
        .IWR_EN_i(IWR_EN), .IR_EN_i(IR_EN), .instr_o(instr_o)
    );

    task automatic issue(input logic [5:0] op, input logic [31:0] pc, a, b, imm, r2,
                         input logic [4:0] rd, input logic rwr, dr, dwr);
        ALUop = op; PC = pc; opA = a; opB = b; immed = imm; R2 = r2;
        RD = rd; RWR_EN = rwr; DR_EN = dr; DWR_EN = dwr;
    endtask

    task automatic idle();
        issue(6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference for the EX stage
    function automatic void model_ex(input int op, input logic [31:0] pc, a, b, imm,
                                     output logic [31:0] res, output logic be,
                                     output logic [31:0] npc);
        int sh;
        logic lt_s, lt_u;
        sh   = int'(b & 32'h1F);
        lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        lt_u = a < b;
        res  = 32'h0;
        be   = 1'b0;
        npc  = pc + 32'd4;
        case (op)
            0:  res = a + b;
            1:  res = a - b;
            2:  res = a << sh;
            3:  res = lt_s ? 32'd1 : 32'd0;
            4:  res = lt_u ? 32'd1 : 32'd0;
            5:  res = a ^ b;
            6:  res = a >> sh;
            7: begin
                res = a >> sh;
                if (a[31] && sh != 0) res = res | ~(32'hFFFF_FFFF >> sh);
            end
            8:  res = a | b;
            9:  res = a & b;
            16: be = (a == b);
            17: be = (a != b);
            18: be = lt_s;
            19: be = !lt_s;
            20: be = lt_u;
            21: be = !lt_u;
            24: begin be = 1'b1; res = pc + 32'd4; end
            25: begin be = 1'b1; res = pc + 32'd4; end
            26: res = imm;
            27: res = pc + imm;
            default: ;
        endcase
        if (be) npc = (op == 25) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        issue(6'd0, 32'h100, 32'd5, 32'd7, 32'h4, 32'h55, 5'd3, 1'b1, 1'b0, 1'b0);
        IADDR = 32'h0; IDATA = 32'h0; IWR_EN = 1'b0; IR_EN = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({result_o, BE_o, PC_o} !== 65'h0) begin
            n_fail++;
            $display("FAIL reset_ex: got result=%h BE=%b PC=%h, want all zero", result_o, BE_o, PC_o);
        end
        n_checks++;
        if ({WR_o, RD_o, RWR_EN_o} !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_wb: got WR=%h RD=%0d RWR_EN=%b, want all zero", WR_o, RD_o, RWR_EN_o);
        end
        n_checks++;
        if (instr_o !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL reset_nop: got instr=%h, want 00000013", instr_o);
        end
        rst_ni = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_alu();
        issue(6'd0, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (result_o !== 32'd12) begin
            n_fail++;
            $display("FAIL add_ex: got %h, want 0000000c", result_o);
        end
        issue(6'd1, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({WR_o, RD_o, RWR_EN_o} !== {32'd12, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wb: got WR=%h RD=%0d EN=%b, want 0000000c 3 1", WR_o, RD_o, RWR_EN_o);
        end
        n_checks++;
        if (result_o !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL sub_ex: got %h, want fffffffe", result_o);
        end
        issue(6'd7, 32'h0, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (result_o !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL sra_ex: got %h, want f8000000", result_o);
        end
        issue(6'd10, 32'h80, 32'd5, 32'd7, 32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({result_o, BE_o, PC_o} !== {32'h0, 1'b0, 32'h84}) begin
            n_fail++;
            $display("FAIL illegal_op: got result=%h BE=%b PC=%h, want 0 0 00000084", result_o, BE_o, PC_o);
        end
    endtask

    task automatic test_branch();
        issue(6'd18, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({result_o, BE_o, PC_o} !== {32'h0, 1'b1, 32'h120}) begin
            n_fail++;
            $display("FAIL blt_taken: got result=%h BE=%b PC=%h, want 0 1 00000120", result_o, BE_o, PC_o);
        end
        issue(6'd20, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({BE_o, PC_o} !== {1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL bltu_not_taken: got BE=%b PC=%h, want 0 00000104", BE_o, PC_o);
        end
    endtask

    task automatic test_jump();
        issue(6'd24, 32'h40, 32'h0, 32'h0, 32'd8, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({result_o, BE_o, PC_o} !== {32'h44, 1'b1, 32'h48}) begin
            n_fail++;
            $display("FAIL jal: got result=%h BE=%b PC=%h, want 00000044 1 00000048", result_o, BE_o, PC_o);
        end
        issue(6'd25, 32'h200, 32'h101, 32'h0, 32'd2, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({result_o, BE_o, PC_o} !== {32'h204, 1'b1, 32'h102}) begin
            n_fail++;
            $display("FAIL jalr: got result=%h BE=%b PC=%h, want 00000204 1 00000102", result_o, BE_o, PC_o);
        end
    endtask

    task automatic test_memory();
        issue(6'd0, 32'h0, 32'h10, 32'h0, 32'h4, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        issue(6'd0, 32'h0, 32'h14, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        issue(6'd0, 32'h0, 32'h414, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({WR_o, RD_o} !== {32'hDEAD_BEEF, 5'd5}) begin
            n_fail++;
            $display("FAIL store_then_load: got WR=%h RD=%0d, want deadbeef 5", WR_o, RD_o);
        end
        issue(6'd0, 32'h0, 32'h14, 32'h0, 32'h0, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (WR_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL alias_load: got WR=%h, want deadbeef", WR_o);
        end
        issue(6'd0, 32'h0, 32'h0, 32'h0, 32'h14, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({WR_o, RD_o} !== {32'hDEAD_BEEF, 5'd7}) begin
            n_fail++;
            $display("FAIL load_store_same: got WR=%h RD=%0d, want deadbeef 7", WR_o, RD_o);
        end
        idle();
        tick();
        n_checks++;
        if (WR_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL load_after_dual: got WR=%h, want 12345678", WR_o);
        end
    endtask

    task automatic test_iccm();
        IADDR = 32'h8; IDATA = 32'hAAAA_5555; IWR_EN = 1'b1; IR_EN = 1'b0;
        tick();
        IDATA = 32'h0050_0093; IR_EN = 1'b1;
        #1;
        n_checks++;
        if (instr_o !== 32'hAAAA_5555) begin
            n_fail++;
            $display("FAIL iccm_rw_same_cycle: got %h, want aaaa5555", instr_o);
        end
        tick();
        IWR_EN = 1'b0; IADDR = 32'h40B;
        #1;
        n_checks++;
        if (instr_o !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL iccm_read: got %h, want 00500093", instr_o);
        end
        IR_EN = 1'b0;
        #1;
        n_checks++;
        if (instr_o !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL iccm_disabled: got %h, want 00000013", instr_o);
        end
    endtask

    task automatic test_reset_midstream();
        issue(6'd0, 32'h0, 32'h20, 32'h0, 32'h4, 32'h1111_1111, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        issue(6'd0, 32'h300, 32'h20, 32'd9, 32'h4, 32'h2222_2222, 5'd2, 1'b1, 1'b0, 1'b1);
        tick();
        rst_ni = 1'b0;
        IADDR = 32'h8; IDATA = 32'hBAD0_BAD0; IWR_EN = 1'b1;
        issue(6'd24, 32'h300, 32'h1, 32'h2, 32'h8, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({result_o, BE_o, PC_o, WR_o, RD_o, RWR_EN_o} !== 103'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got result=%h BE=%b PC=%h WR=%h RD=%0d EN=%b, want all zero",
                     result_o, BE_o, PC_o, WR_o, RD_o, RWR_EN_o);
        end
        rst_ni = 1'b1;
        IWR_EN = 1'b0;
        issue(6'd0, 32'h0, 32'h24, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (RWR_EN_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_refill_early: got RWR_EN=%b, want 0", RWR_EN_o);
        end
        idle();
        tick();
        n_checks++;
        if ({WR_o, RD_o, RWR_EN_o} !== {32'h1111_1111, 5'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_store_dropped: got WR=%h RD=%0d EN=%b, want 11111111 9 1", WR_o, RD_o, RWR_EN_o);
        end
        IR_EN = 1'b1;
        #1;
        n_checks++;
        if (instr_o !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL reset_iccm_write: got %h, want 00500093", instr_o);
        end
        IR_EN = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 300;
        int ops [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21,
                         24, 25, 26, 27, 10, 31, 63, 3};
        logic [31:0] mmem [256];
        logic [31:0] e_res [N];
        logic [31:0] e_pc  [N];
        logic [31:0] e_sd  [N];
        logic        e_be  [N];
        logic        e_dr  [N];
        logic        e_dwr [N];
        logic        e_rwr [N];
        logic [4:0]  e_rd  [N];
        int          e_idx [N];
        logic [31:0] wb, ea, a, b, imm, pc;
        int op, idx;
        for (int i = 0; i < N + 1; i++) begin
            if (i < N) begin
                op  = ops[$urandom_range(0, 23)];
                pc  = $urandom & 32'hFFFF_FFFC;
                b   = $urandom;
                imm = $urandom;
                idx = 32 + ((i < 16) ? i : $urandom_range(0, 15));
                ea  = ($urandom & ~32'h0000_03FC) | (32'(idx) << 2);
                a   = ea - imm;
                if ($urandom_range(0, 3) == 0) b = a;
                e_dwr[i] = (i < 16) ? 1'b1 : ($urandom_range(0, 3) == 0);
                e_dr[i]  = (i < 16) ? 1'b0 : ($urandom_range(0, 2) == 0);
                e_rwr[i] = 1'($urandom_range(0, 1));
                e_rd[i]  = 5'($urandom);
                e_sd[i]  = $urandom;
                e_idx[i] = idx;
                model_ex(op, pc, a, b, imm, e_res[i], e_be[i], e_pc[i]);
                issue(6'(op), pc, a, b, imm, e_sd[i], e_rd[i], e_rwr[i], e_dr[i], e_dwr[i]);
            end else begin
                idle();
            end
            tick();
            if (i >= 1) begin
                wb = e_dr[i-1] ? mmem[e_idx[i-1]] : e_res[i-1];
                if (e_dwr[i-1]) mmem[e_idx[i-1]] = e_sd[i-1];
                n_checks++;
                if ({WR_o, RD_o, RWR_EN_o} !== {wb, e_rd[i-1], e_rwr[i-1]}) begin
                    n_fail++;
                    $display("FAIL rand_wb[%0d]: got WR=%h RD=%0d EN=%b, want %h %0d %b",
                             i - 1, WR_o, RD_o, RWR_EN_o, wb, e_rd[i-1], e_rwr[i-1]);
                end
            end
            if (i < N) begin
                n_checks++;
                if ({result_o, BE_o, PC_o} !== {e_res[i], e_be[i], e_pc[i]}) begin
                    n_fail++;
                    $display("FAIL rand_ex[%0d] op=%0d: got result=%h BE=%b PC=%h, want %h %b %h",
                             i, ALUop, result_o, BE_o, PC_o, e_res[i], e_be[i], e_pc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_memory();
        test_iccm();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
